// File: rtl/mem_copy_dma_pkg.sv
// Shared definitions for the memory-copy DMA: default memory size and
// the controller state encoding.
package mem_copy_dma_pkg;

    localparam int MEM_SIZE_DEF = 32;
    localparam int STATE_W      = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } dma_state_e;

endpackage

// File: rtl/mem_copy_dma_if.sv
// Word-addressed data memory port: combinational read, posedge write.
// The DMA is the only initiator; the memory is the only responder.
// No handshake: a strobe is accepted in the cycle it is high. mem_memR
// means mem_rdata must be valid in that same cycle; mem_memW means the
// memory writes mem_wdata at mem_addr on the next posedge.
interface mem_copy_dma_if;
    import mem_copy_dma_pkg::*;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_memR;
    logic        mem_memW;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_memR,
        output mem_memW,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_memR,
        input  mem_memW,
        output mem_rdata
    );

endinterface

// File: rtl/mem_copy_dma.sv
// Block-copy engine: moves len words from src to dst, one read cycle then
// one write cycle per word, strictly ascending. All outputs are registered,
// including the strobes, so an asynchronous reset drops them at once.
module mem_copy_dma
    import mem_copy_dma_pkg::*;
#(
    parameter int MEM_SIZE = MEM_SIZE_DEF,
    parameter int AW       = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [AW-1:0]   src,
    input  logic [AW-1:0]   dst,
    input  logic [AW-1:0]   len,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            aborted,
    output logic [AW-1:0]   count,
    output dma_state_e      state_dbg,
    mem_copy_dma_if.master  mem
);

    localparam logic [AW:0] MEM_LIMIT = (AW+1)'(MEM_SIZE);

    dma_state_e    state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] len_q, len_d;
    logic [AW-1:0] count_q, count_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   buf_q, buf_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          aborted_q, aborted_d;
    logic          memr_q, memr_d;
    logic          memw_q, memw_d;

    logic [AW-1:0] count_inc;
    logic [AW:0]   src_end;
    logic [AW:0]   dst_end;
    logic          range_bad;

    // Range check one bit wider than the address so a huge len cannot wrap past it.
    assign count_inc = count_q + AW'(1);
    assign src_end   = {1'b0, src} + {1'b0, len};
    assign dst_end   = {1'b0, dst} + {1'b0, len};
    assign range_bad = (src_end > MEM_LIMIT) || (dst_end > MEM_LIMIT);

    // Next-state and next-output computation for the copy controller.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        count_d   = count_q;
        addr_d    = addr_q;
        buf_d     = buf_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        aborted_d = aborted_q;
        memr_d    = 1'b0;
        memw_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    src_d     = src;
                    dst_d     = dst;
                    len_d     = len;
                    count_d   = '0;
                    err_d     = 1'b0;
                    aborted_d = 1'b0;
                    busy_d    = 1'b1;
                    if (len == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (range_bad) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_READ;
                        memr_d  = 1'b1;
                        addr_d  = src;
                    end
                end
            end
            ST_READ: begin
                // The read always completes; abort only skips the write.
                buf_d = mem.mem_rdata;
                if (abort) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else begin
                    state_d = ST_WRITE;
                    memw_d  = 1'b1;
                    addr_d  = dst_q + count_q;
                end
            end
            ST_WRITE: begin
                count_d = count_inc;
                if ((count_inc == len_q) || abort) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    aborted_d = abort && (count_inc != len_q);
                end else begin
                    state_d = ST_READ;
                    memr_d  = 1'b1;
                    addr_d  = src_q + count_inc;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Controller state and registered outputs; reset is immediate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            count_q   <= '0;
            addr_q    <= '0;
            buf_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
            memr_q    <= 1'b0;
            memw_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            buf_q     <= buf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
            memr_q    <= memr_d;
            memw_q    <= memw_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign aborted       = aborted_q;
    assign count         = count_q;
    assign state_dbg     = state_q;
    assign mem.mem_addr  = 32'(addr_q);
    assign mem.mem_wdata = buf_q;
    assign mem.mem_memR  = memr_q;
    assign mem.mem_memW  = memw_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: a behavioural word memory as responder and a
// reference memory image updated by plain ascending word copies.
module tb_mem_copy_dma;
    import mem_copy_dma_pkg::*;

    localparam int MSZ = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start, abort;
    logic [31:0] src, dst, len;
    logic        busy, done, err, aborted;
    logic [31:0] count;
    dma_state_e  state_dbg;

    mem_copy_dma_if mem_if ();

    mem_copy_dma #(.MEM_SIZE(MSZ), .AW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .aborted   (aborted),
        .count     (count),
        .state_dbg (state_dbg),
        .mem       (mem_if.master)
    );

    // ---------------- memory responder ----------------
    logic [31:0] mem_arr [0:MSZ-1];
    logic [31:0] ref_mem [0:MSZ-1];
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;

    assign mem_if.mem_rdata = (mem_if.mem_addr < MSZ) ? mem_arr[mem_if.mem_addr[4:0]] : 32'h0;

    always @(posedge clk) begin
        if (ld_en)
            mem_arr[ld_addr] <= ld_data;
        else if (mem_if.mem_memW && (mem_if.mem_addr < MSZ))
            mem_arr[mem_if.mem_addr[4:0]] <= mem_if.mem_wdata;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_word(input int a, input logic [31:0] v);
        ld_en = 1'b1; ld_addr = a[4:0]; ld_data = v;
        tick();
        ld_en = 1'b0;
        ref_mem[a] = v;
    endtask

    task automatic load_random_image();
        for (int i = 0; i < MSZ; i++) load_word(i, $urandom);
    endtask

    // Reference: the copy is ascending, so overlapping ranges propagate words.
    task automatic model_copy(input int s, input int d, input int n);
        for (int i = 0; i < n; i++) ref_mem[d+i] = ref_mem[s+i];
    endtask

    task automatic check_image(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < MSZ; i++) if (mem_arr[i] !== ref_mem[i]) bad++;
        n_checks++;
        if (bad != 0) begin
            $display("FAIL %s mem_image: %0d words differ from required image", tag, bad);
            for (int i = 0; i < MSZ; i++)
                if (mem_arr[i] !== ref_mem[i])
                    $display("  word %0d got %h required %h", i, mem_arr[i], ref_mem[i]);
        end else n_pass++;
    endtask

    // Issues one start and watches until done (bounded). Cycle 1 is the
    // first cycle after the accepting edge.
    task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                           input int abort_cyc, output int done_cyc,
                           output logic saw_r, output logic saw_w, output logic both,
                           output logic busy_gap, output logic o_err,
                           output logic o_ab, output logic [31:0] o_cnt);
        start = 1'b1; src = s; dst = d; len = l;
        tick();
        start = 1'b0;
        done_cyc = -1; saw_r = 0; saw_w = 0; both = 0; busy_gap = 0;
        o_err = 0; o_ab = 0; o_cnt = 0;
        for (int c = 1; c <= 200; c++) begin
            if (mem_if.mem_memR) saw_r = 1;
            if (mem_if.mem_memW) saw_w = 1;
            if (mem_if.mem_memR && mem_if.mem_memW) both = 1;
            if (!busy) busy_gap = 1;
            if (c == abort_cyc) abort = 1'b1;
            if (done) begin
                done_cyc = c; o_err = err; o_ab = aborted; o_cnt = count;
                break;
            end
            tick();
        end
        abort = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        #3;
        n_checks++;
        if ({busy, done, err, aborted, mem_if.mem_memR, mem_if.mem_memW} !== 6'b0)
            $display("FAIL reset_flags: got %b required 000000",
                     {busy, done, err, aborted, mem_if.mem_memR, mem_if.mem_memW});
        else n_pass++;
        n_checks++;
        if ({count, mem_if.mem_addr, mem_if.mem_wdata} !== 96'h0)
            $display("FAIL reset_regs: count %h addr %h wdata %h required 0", count,
                     mem_if.mem_addr, mem_if.mem_wdata);
        else n_pass++;
        n_checks++;
        if (state_dbg !== ST_IDLE) $display("FAIL reset_state: got %0d required 0", state_dbg);
        else n_pass++;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int dc; logic r, w, b, g, e, a; logic [31:0] c;
        for (int i = 0; i < 4; i++) load_word(i, $urandom);
        do_copy(0, 8, 4, -1, dc, r, w, b, g, e, a, c);
        model_copy(0, 8, 4);
        n_checks++;
        if (dc !== 9) $display("FAIL basic_done_cycle: got %0d required 9", dc); else n_pass++;
        n_checks++;
        if (c !== 4 || e !== 1'b0 || a !== 1'b0)
            $display("FAIL basic_status: count %0d err %b aborted %b required 4 0 0", c, e, a);
        else n_pass++;
        n_checks++;
        if (b || g) $display("FAIL basic_strobes: both %b busy_gap %b required 0 0", b, g);
        else n_pass++;
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || count !== 4)
            $display("FAIL basic_idle: busy %b done %b count %0d required 0 0 4", busy, done, count);
        else n_pass++;
        check_image("basic");
    endtask

    task automatic test_zero_len();
        int dc; logic r, w, b, g, e, a; logic [31:0] c;
        do_copy(5, 6, 0, -1, dc, r, w, b, g, e, a, c);
        n_checks++;
        if (dc !== 1 || e !== 1'b0 || c !== 0 || r || w)
            $display("FAIL zero_len: done %0d err %b count %0d memR %b memW %b required 1 0 0 0 0",
                     dc, e, c, r, w);
        else n_pass++;
        tick();
        check_image("zero_len");
    endtask

    task automatic test_range_err();
        int dc; logic r, w, b, g, e, a; logic [31:0] c;
        do_copy(30, 0, 4, -1, dc, r, w, b, g, e, a, c);
        n_checks++;
        if (dc !== 1 || e !== 1'b1 || r || w)
            $display("FAIL range_src: done %0d err %b memR %b memW %b required 1 1 0 0", dc, e, r, w);
        else n_pass++;
        tick();
        do_copy(0, 29, 4, -1, dc, r, w, b, g, e, a, c);
        n_checks++;
        if (dc !== 1 || e !== 1'b1 || r || w)
            $display("FAIL range_dst: done %0d err %b memR %b memW %b required 1 1 0 0", dc, e, r, w);
        else n_pass++;
        tick();
        // src+len wraps to 0 in 32 bits; only a wide compare rejects it
        do_copy(1, 2, 32'hFFFF_FFFF, -1, dc, r, w, b, g, e, a, c);
        n_checks++;
        if (dc !== 1 || e !== 1'b1 || r || w)
            $display("FAIL range_wrap: done %0d err %b memR %b memW %b required 1 1 0 0", dc, e, r, w);
        else n_pass++;
        tick();
        check_image("range_err");
        // exactly touching the top of memory is legal
        do_copy(28, 0, 4, -1, dc, r, w, b, g, e, a, c);
        model_copy(28, 0, 4);
        n_checks++;
        if (dc !== 9 || e !== 1'b0 || c !== 4)
            $display("FAIL range_edge: done %0d err %b count %0d required 9 0 4", dc, e, c);
        else n_pass++;
        tick();
        check_image("range_edge");
    endtask

    task automatic test_overlap();
        int dc; logic r, w, b, g, e, a; logic [31:0] c;
        load_word(0, 32'd11);
        load_word(1, 32'd22);
        do_copy(0, 1, 2, -1, dc, r, w, b, g, e, a, c);
        tick();
        n_checks++;
        if (mem_arr[1] !== 32'd11 || mem_arr[2] !== 32'd11)
            $display("FAIL overlap: mem1 %0d mem2 %0d required 11 11", mem_arr[1], mem_arr[2]);
        else n_pass++;
        model_copy(0, 1, 2);
        check_image("overlap");
    endtask

    task automatic test_abort();
        int dc; logic r, w, b, g, e, a; logic [31:0] c;
        // abort held during the 2nd write (cycle 4)
        do_copy(0, 16, 4, 4, dc, r, w, b, g, e, a, c);
        model_copy(0, 16, 2);
        n_checks++;
        if (dc !== 5 || a !== 1'b1 || c !== 2 || e !== 1'b0)
            $display("FAIL abort_write: done %0d aborted %b count %0d err %b required 5 1 2 0",
                     dc, a, c, e);
        else n_pass++;
        tick();
        check_image("abort_write");
        // abort during the 2nd read: read completes, write skipped
        do_copy(4, 20, 4, 3, dc, r, w, b, g, e, a, c);
        model_copy(4, 20, 1);
        n_checks++;
        if (dc !== 4 || a !== 1'b1 || c !== 1)
            $display("FAIL abort_read: done %0d aborted %b count %0d required 4 1 1", dc, a, c);
        else n_pass++;
        tick();
        check_image("abort_read");
        // abort on the final write finishes normally
        do_copy(6, 24, 2, 4, dc, r, w, b, g, e, a, c);
        model_copy(6, 24, 2);
        n_checks++;
        if (dc !== 5 || a !== 1'b0 || c !== 2)
            $display("FAIL abort_last: done %0d aborted %b count %0d required 5 0 2", dc, a, c);
        else n_pass++;
        tick();
        check_image("abort_last");
    endtask

    task automatic test_reset_mid_read();
        int dc; logic r, w, b, g, e, a; logic [31:0] c;
        start = 1'b1; src = 0; dst = 8; len = 4;
        tick();
        start = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (mem_if.mem_memR !== 1'b0 || mem_if.mem_memW !== 1'b0 || busy !== 1'b0
            || state_dbg !== ST_IDLE)
            $display("FAIL reset_mid_read: memR %b memW %b busy %b state %0d required 0 0 0 0",
                     mem_if.mem_memR, mem_if.mem_memW, busy, state_dbg);
        else n_pass++;
        tick();
        reset = 1'b1;
        tick();
        check_image("reset_mid_read");
        // a start pulse while busy must not queue a second copy
        fork
            do_copy(8, 12, 4, -1, dc, r, w, b, g, e, a, c);
            begin
                tick(); tick();
                start = 1'b1; src = 0; dst = 26; len = 2;
                tick();
                start = 1'b0;
            end
        join
        model_copy(8, 12, 4);
        n_checks++;
        if (dc !== 9 || c !== 4)
            $display("FAIL start_ignored: done %0d count %0d required 9 4", dc, c);
        else n_pass++;
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL start_ignored_idle: busy %b required 0", busy);
        else n_pass++;
        check_image("start_ignored");
    endtask

    task automatic test_random();
        int dc; logic r, w, b, g, e, a; logic [31:0] c;
        int l, s, d;
        load_random_image();
        for (int k = 0; k < 10; k++) begin
            l = $urandom_range(1, 8);
            s = $urandom_range(0, MSZ - l);
            d = $urandom_range(0, MSZ - l);
            do_copy(s, d, l, -1, dc, r, w, b, g, e, a, c);
            model_copy(s, d, l);
            n_checks++;
            if (dc !== 2*l + 1 || c !== l || e !== 1'b0 || a !== 1'b0 || b || g)
                $display("FAIL random_%0d: src %0d dst %0d len %0d done %0d count %0d err %b ab %b both %b gap %b required done %0d count %0d",
                         k, s, d, l, dc, c, e, a, b, g, 2*l + 1, l);
            else n_pass++;
            tick();
            check_image("random");
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        start = 0; abort = 0; src = 0; dst = 0; len = 0;
        ld_en = 0; ld_addr = 0; ld_data = 0;
        for (int i = 0; i < MSZ; i++) begin
            mem_arr[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        test_reset();
        load_random_image();
        test_basic();
        test_zero_len();
        test_range_err();
        test_overlap();
        test_abort();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
